// File: rtl/div_pkg.sv
// Shared widths, latency and record types for the scheduled divider slice.
package div_pkg;

  localparam int OPA_W = 50;
  localparam int OPB_W = 24;
  localparam int RES_W = 50;
  localparam int LAT   = 2;

  typedef struct packed {
    logic valid;
    logic id;
    logic dz;
  } tag_t;

  typedef struct packed {
    logic [RES_W-1:0] quo;
    logic [RES_W-1:0] rem;
    logic             dz;
  } res_t;

endpackage

// File: rtl/div_r2.sv
// Two-cycle pipelined restoring divider: upper quotient half resolved in the
// first stage, lower half in the second. Results are registered after stage two.
module div_r2 import div_pkg::*; (
  input  logic             clk,
  input  logic [OPA_W-1:0] i_opa,
  input  logic [OPB_W-1:0] i_opb,
  output logic [RES_W-1:0] o_quo,
  output logic [RES_W-1:0] o_rem
);

  localparam int HI = OPA_W / 2;
  localparam int LO = OPA_W - HI;

  logic [OPB_W-1:0] w_rem1;
  logic [HI-1:0]    w_q1;
  logic [OPB_W-1:0] w_rem2;
  logic [LO-1:0]    w_q2;

  logic [HI-1:0]    r_qhi;
  logic [OPB_W-1:0] r_rem1;
  logic [LO-1:0]    r_alo;
  logic [OPB_W-1:0] r_b;
  logic [RES_W-1:0] r_quo;
  logic [OPB_W-1:0] r_rem;

  always_comb begin
    logic [OPB_W:0] t;
    w_rem1 = '0;
    w_q1   = '0;
    t      = '0;
    for (int k = HI - 1; k >= 0; k--) begin
      t = {w_rem1, i_opa[LO+k]};
      if (t >= {1'b0, i_opb}) begin
        t       = t - {1'b0, i_opb};
        w_q1[k] = 1'b1;
      end
      w_rem1 = t[OPB_W-1:0];
    end
  end

  // The partial remainder is always below the divisor, so it fits in OPB_W bits.
  always_comb begin
    logic [OPB_W:0] t;
    w_rem2 = r_rem1;
    w_q2   = '0;
    t      = '0;
    for (int k = LO - 1; k >= 0; k--) begin
      t = {w_rem2, r_alo[k]};
      if (t >= {1'b0, r_b}) begin
        t       = t - {1'b0, r_b};
        w_q2[k] = 1'b1;
      end
      w_rem2 = t[OPB_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    r_qhi  <= w_q1;
    r_rem1 <= w_rem1;
    r_alo  <= i_opa[LO-1:0];
    r_b    <= i_opb;
    r_quo  <= {r_qhi, w_q2};
    r_rem  <= w_rem2;
  end

  assign o_quo = r_quo;
  assign o_rem = {{(RES_W-OPB_W){1'b0}}, r_rem};

endmodule

// File: rtl/div_sched.sv
// Two-requester front end for one shared pipelined divider: credit-based
// round-robin issue, tag pipeline, and per-requester first-word-fall-through FIFOs.
module div_sched import div_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [OPA_W-1:0] in0_opa,
  input  logic [OPB_W-1:0] in0_opb,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [OPA_W-1:0] in1_opa,
  input  logic [OPB_W-1:0] in1_opb,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [RES_W-1:0] out0_quo,
  output logic [RES_W-1:0] out0_rem,
  output logic             out0_dz,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [RES_W-1:0] out1_quo,
  output logic [RES_W-1:0] out1_rem,
  output logic             out1_dz,
  output logic             busy
);

  // Handshakes: a transfer happens in any cycle where valid && ready are both
  // high at the rising edge; valid never depends on ready, ready may depend on valid.

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW1-1:0] L_DEPTH = CW1'(DEPTH);
  localparam logic [PW-1:0]  L_LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0]  C_ONE   = CW'(1);

  logic [1:0]       w_in_valid;
  logic [1:0]       w_out_ready;
  logic [1:0]       w_out_valid;
  logic [1:0]       w_credit;
  logic [1:0]       w_elig;
  logic [1:0]       w_grant;
  logic [1:0]       w_wr;
  logic [1:0]       w_pop;
  logic             w_gid;
  logic [OPA_W-1:0] w_div_a;
  logic [OPB_W-1:0] w_div_b;
  logic [RES_W-1:0] w_div_quo;
  logic [RES_W-1:0] w_div_rem;
  tag_t             w_tag_out;
  logic             w_tag_any;
  res_t             w_wdata;
  res_t             w_head [2];

  logic [CW-1:0]    r_infl [2];
  logic [CW-1:0]    r_occ  [2];
  logic [PW-1:0]    r_wptr [2];
  logic [PW-1:0]    r_rptr [2];
  res_t             r_mem  [2][DEPTH];
  tag_t             r_tag  [LAT];
  logic             r_last;

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == L_LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_in_valid  = {in1_valid, in0_valid};
  assign w_out_ready = {out1_ready, out0_ready};

  always_comb begin
    w_credit = '0;
    w_elig   = '0;
    for (int i = 0; i < 2; i++) begin
      w_credit[i] = ({1'b0, r_infl[i]} + {1'b0, r_occ[i]}) < L_DEPTH;
      w_elig[i]   = rst_n && w_in_valid[i] && w_credit[i];
    end
  end

  // r_last = 1 means requester 1 won the previous grant, so requester 0 wins a tie.
  always_comb begin
    w_gid   = (w_elig == 2'b10) || ((w_elig == 2'b11) && !r_last);
    w_grant = (w_elig == 2'b00) ? 2'b00 : (w_gid ? 2'b10 : 2'b01);
    w_div_a = w_gid ? in1_opa : in0_opa;
    w_div_b = w_gid ? in1_opb : in0_opb;
  end

  div_r2 u_div (
    .clk   (clk),
    .i_opa (w_div_a),
    .i_opb (w_div_b),
    .o_quo (w_div_quo),
    .o_rem (w_div_rem)
  );

  assign w_tag_out = r_tag[LAT-1];
  assign w_wr[0]   = w_tag_out.valid && !w_tag_out.id;
  assign w_wr[1]   = w_tag_out.valid &&  w_tag_out.id;

  always_comb begin
    if (w_tag_out.dz) begin
      w_wdata = '{quo: '1, rem: '0, dz: 1'b1};
    end else begin
      w_wdata = '{quo: w_div_quo, rem: w_div_rem, dz: 1'b0};
    end
  end

  always_comb begin
    w_tag_any = 1'b0;
    for (int s = 0; s < LAT; s++) begin
      w_tag_any = w_tag_any | r_tag[s].valid;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_head[i]      = r_mem[i][r_rptr[i]];
      w_out_valid[i] = rst_n && (r_occ[i] != '0);
      w_pop[i]       = w_out_valid[i] && w_out_ready[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      for (int s = 0; s < LAT; s++) begin
        r_tag[s] <= '0;
      end
      for (int i = 0; i < 2; i++) begin
        r_infl[i] <= '0;
        r_occ[i]  <= '0;
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
    end else begin
      if (|w_grant) begin
        r_last <= w_gid;
      end
      r_tag[0] <= '{valid: |w_grant, id: w_gid, dz: (w_div_b == '0)};
      for (int s = 1; s < LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
      for (int i = 0; i < 2; i++) begin
        case ({w_grant[i], w_wr[i]})
          2'b10:   r_infl[i] <= r_infl[i] + C_ONE;
          2'b01:   r_infl[i] <= r_infl[i] - C_ONE;
          default: r_infl[i] <= r_infl[i];
        endcase
        case ({w_wr[i], w_pop[i]})
          2'b10:   r_occ[i] <= r_occ[i] + C_ONE;
          2'b01:   r_occ[i] <= r_occ[i] - C_ONE;
          default: r_occ[i] <= r_occ[i];
        endcase
        if (w_wr[i]) begin
          r_wptr[i] <= nxt_ptr(r_wptr[i]);
        end
        if (w_pop[i]) begin
          r_rptr[i] <= nxt_ptr(r_rptr[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n && w_wr[i]) begin
        r_mem[i][r_wptr[i]] <= w_wdata;
      end
    end
  end

  // The credit rule keeps inflight + occupancy within DEPTH, so a write never finds a full FIFO.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n && w_wr[i]) begin
        assert ({1'b0, r_occ[i]} < L_DEPTH);
      end
    end
  end

  assign in0_ready  = w_grant[0];
  assign in1_ready  = w_grant[1];
  assign out0_valid = w_out_valid[0];
  assign out1_valid = w_out_valid[1];
  assign out0_quo   = w_out_valid[0] ? w_head[0].quo : '0;
  assign out0_rem   = w_out_valid[0] ? w_head[0].rem : '0;
  assign out0_dz    = w_out_valid[0] ? w_head[0].dz  : 1'b0;
  assign out1_quo   = w_out_valid[1] ? w_head[1].quo : '0;
  assign out1_rem   = w_out_valid[1] ? w_head[1].rem : '0;
  assign out1_dz    = w_out_valid[1] ? w_head[1].dz  : 1'b0;
  assign busy       = rst_n && ((r_infl[0] != '0) || (r_infl[1] != '0) ||
                                (r_occ[0] != '0)  || (r_occ[1] != '0)  || w_tag_any);

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 2: per-requester result FIFO depth and per-requester outstanding limit.
REQ-002 SHALL have parameter LAT, default 2: shared divider latency in cycles; fixed to 2 for the instantiated divider.
REQ-003 SHALL have one clock and a synchronous, active-low reset: clk input 1 (all state on rising edge), then rst_n input 1.
REQ-004 SHALL have port in0_valid input 1: requester 0 operation present.
REQ-005 SHALL have port in0_ready output 1: requester 0 operation accepted this cycle.
REQ-006 SHALL have port in0_opa input 50: requester 0 dividend.
REQ-007 SHALL have port in0_opb input 24: requester 0 divisor.
REQ-008 SHALL have ports in1_valid, in1_ready, in1_opa and in1_opb, identical to REQ-004..007 for requester 1.
REQ-009 SHALL have port out0_valid output 1: requester 0 result available.
REQ-010 SHALL have port out0_ready input 1: requester 0 consumes the result.
REQ-011 SHALL have port out0_quo output 50: quotient.
REQ-012 SHALL have port out0_rem output 50: remainder.
REQ-013 SHALL have port out0_dz output 1: the divisor was zero.
REQ-014 SHALL have ports out1_valid, out1_ready, out1_quo, out1_rem and out1_dz, identical to REQ-009..013 for requester 1.
REQ-015 SHALL have port busy output 1: any operation in flight or any FIFO non-empty.

Function
REQ-016 SHALL compute credit_i = (inflight_i + occ_i < DEPTH) from registered counts at cycle start; pops in the same cycle do not add credit until the next cycle.
REQ-017 SHALL compute eligibility e_i = in_i_valid && credit_i.
REQ-018 SHALL grant at most one requester per cycle; in_i_ready = grant_i (combinational from valid is allowed).
REQ-019 SHALL grant the only eligible requester when exactly one is eligible.
REQ-020 SHALL, when both are eligible, grant the requester not granted last (round-robin); register last_grant only on a grant.
REQ-021 SHALL drive the divider operands from the granted requester's opa/opb via a mux; with no grant, operands are don't-care and no tag is issued.
REQ-022 SHALL push a tag {valid, id, dz = (opb == 0)} into a LAT-stage shift register, aligned with the divider pipeline.
REQ-023 SHALL, when a tag emerges in cycle t+2 for an operation accepted in cycle t, write the divider quo/rem into FIFO[id] at the end of t+2; out_id_valid rises in cycle t+3 at the earliest.
REQ-024 SHALL, when dz = 1, store quo = all ones (50 bits), rem = 0 and dz = 1, ignoring divider output.
REQ-025 SHALL, for each requester, increment inflight_i on grant and decrement it on FIFO write; simultaneous increment and decrement leave it unchanged.
REQ-026 SHALL, for each requester, increment occ_i on write and decrement it on pop (out_valid && out_ready); simultaneous write and pop leave it unchanged.
REQ-027 SHALL treat the FIFOs as first-word-fall-through; outputs hold stable while valid && !ready.
REQ-028 SHALL ensure FIFO overflow is impossible by the REQ-016 credit rule; a write to a full FIFO is an assertion failure.
REQ-029 SHALL deliver each requester's results in acceptance order.
REQ-030 SHALL ensure ports are fully independent in deliveries; one port stalled never blocks the other.
REQ-031 SHALL drive busy = |inflight_0, inflight_1, occ_0, occ_1| or any tag valid.

Reset
REQ-032 SHALL, while rst_n = 0 at a clock edge, clear all counters, tag valid bits and FIFO pointers, and set last_grant = 1 so requester 0 wins the first tie.
REQ-033 SHALL, during reset, hold in*_ready = 0, out*_valid = 0, out*_quo/rem = 0, out*_dz = 0 and busy = 0.
REQ-034 SHALL, on reset mid-operation, discard in-flight divider results (tags cleared), ignore divider data, and produce no spurious outputs after release.

Structure
REQ-035 SHALL define OPA_W = 50, OPB_W = 24, RES_W = 50, LAT = 2 and the tag struct {valid, id, dz} in shared package div_pkg.
REQ-036 SHALL instantiate the codebase's 2-cycle pipelined divider (div_r2) as the only sub-module; FIFOs and arbiter are local logic.

Verification
REQ-037 SHALL cover: in0 opa=100, opb=7 accepted in cycle 0 -> out0_valid in cycle 3, quo=14, rem=2, dz=0.
REQ-038 SHALL cover: both valid continuously with out ready = 1 -> grants alternate 0,1,0,1 and each port receives results in order.
REQ-039 SHALL cover: in1 opa=5, opb=0 -> out1_dz=1, quo=all ones, rem=0.
REQ-040 SHALL cover: out0_ready=0, in0 valid continuously -> exactly DEPTH=2 accepted, then in0_ready=0; port 1 keeps flowing; ready=1 resumes.
REQ-041 SHALL cover: rst_n low 1 cycle after two issues -> no out*_valid ever asserts for them; busy=0 after reset.
REQ-042 SHALL cover: with the FIFO full, pop and grant in the same cycle -> grant denied that cycle, allowed next; counts stay consistent.
